// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the Sargantana instruction-cache refill path.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY_DEF = 4;
  localparam int TAG_WIDHT_DEF    = 20;
  localparam int IDX_WIDHT_DEF    = 6;
  localparam int WAY_WIDHT_DEF    = 512;
  localparam int BEAT_WIDHT_DEF   = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    FLUSH = 3'd4
  } refill_state_e;

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way selection: first invalid way wins, otherwise a round-robin pointer.
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY = ICACHE_N_WAY_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ICACHE_N_WAY-1:0] valid_bits_i,
  input  logic                    advance_i,
  output logic [ICACHE_N_WAY-1:0] victim_o,
  output logic                    from_rr_o
);

  localparam int PTR_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

  logic [PTR_W-1:0] rr_q;
  logic             found;

  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int i = 0; i < ICACHE_N_WAY; i++) begin
      if (!valid_bits_i[i] && !found) begin
        victim_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) victim_o = ICACHE_N_WAY'(1) << rr_q;
    from_rr_o = !found;
  end

  // Pointer only moves when a pointer-chosen victim is actually written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (advance_i) begin
      rr_q <= (rr_q == PTR_W'(ICACHE_N_WAY - 1)) ? '0 : rr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sargantana_icache_refill.sv
// Instruction-cache miss refill FSM: requests a line from L2, assembles beats,
// writes it into the victim way; also sweeps all sets to invalidate on flush.
module sargantana_icache_refill
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY = ICACHE_N_WAY_DEF,
  parameter int TAG_WIDHT    = TAG_WIDHT_DEF,
  parameter int IDX_WIDHT    = IDX_WIDHT_DEF,
  parameter int WAY_WIDHT    = WAY_WIDHT_DEF,
  parameter int BEAT_WIDHT   = BEAT_WIDHT_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           miss_i,
  input  logic [TAG_WIDHT-1:0]           miss_tag_i,
  input  logic [IDX_WIDHT-1:0]           miss_idx_i,
  input  logic [ICACHE_N_WAY-1:0]        way_valid_bits_i,
  input  logic                           flush_i,
  input  logic                           kill_i,
  output logic                           ifill_req_valid_o,
  output logic [TAG_WIDHT+IDX_WIDHT-1:0] ifill_req_addr_o,
  input  logic                           ifill_req_ready_i,
  input  logic                           ifill_resp_valid_i,
  input  logic [BEAT_WIDHT-1:0]          ifill_resp_data_i,
  output logic                           wr_en_o,
  output logic [ICACHE_N_WAY-1:0]        wr_way_o,
  output logic [IDX_WIDHT-1:0]           wr_idx_o,
  output logic [TAG_WIDHT-1:0]           wr_tag_o,
  output logic [WAY_WIDHT-1:0]           wr_data_o,
  output logic                           wr_valid_o,
  output logic                           busy_o,
  output logic                           refill_done_o
);

  localparam int N_BEATS    = WAY_WIDHT / BEAT_WIDHT;
  localparam int BEAT_CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(N_BEATS - 1);

  refill_state_e state_q, state_d;

  logic [BEAT_CNT_W-1:0]   beat_cnt_q;
  logic [IDX_WIDHT-1:0]    set_cnt_q;
  logic                    kill_q;
  logic                    flush_pend_q;
  logic                    from_rr_q;
  logic [TAG_WIDHT-1:0]    tag_q;
  logic [IDX_WIDHT-1:0]    idx_q;
  logic [ICACHE_N_WAY-1:0] victim_q;
  logic [WAY_WIDHT-1:0]    line_q;

  logic [ICACHE_N_WAY-1:0] victim_sel;
  logic                    victim_from_rr;
  logic                    miss_take;
  logic                    beat_take;
  logic                    kill_now;

  sargantana_icache_victim_sel #(
    .ICACHE_N_WAY(ICACHE_N_WAY)
  ) u_victim_sel (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_bits_i(way_valid_bits_i),
    .advance_i   ((state_q == WRITE) && from_rr_q),
    .victim_o    (victim_sel),
    .from_rr_o   (victim_from_rr)
  );

  // A flush (new or pending) pre-empts and drops a coincident miss.
  assign miss_take = (state_q == IDLE) && miss_i && !flush_i && !flush_pend_q;
  assign beat_take = (state_q == WAIT) && ifill_resp_valid_i;
  assign kill_now  = kill_q || (kill_i && ((state_q == REQ) || (state_q == WAIT)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_i || flush_pend_q) state_d = FLUSH;
        else if (miss_i)             state_d = REQ;
      end
      REQ:     if (ifill_req_ready_i) state_d = WAIT;
      WAIT: begin
        if (beat_take && (beat_cnt_q == LAST_BEAT)) state_d = kill_now ? IDLE : WRITE;
      end
      WRITE:   state_d = IDLE;
      FLUSH:   if (set_cnt_q == '1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      set_cnt_q    <= '0;
      kill_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      from_rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) kill_q <= 1'b0;
      else if (kill_i && ((state_q == REQ) || (state_q == WAIT))) kill_q <= 1'b1;
      if (state_q == IDLE) flush_pend_q <= 1'b0;
      else if (flush_i)    flush_pend_q <= 1'b1;
      if (state_q == REQ)  beat_cnt_q <= '0;
      else if (beat_take)  beat_cnt_q <= beat_cnt_q + 1'b1;
      if (state_q == FLUSH) set_cnt_q <= set_cnt_q + 1'b1;
      else                  set_cnt_q <= '0;
      if (miss_take) from_rr_q <= victim_from_rr;
    end
  end

  // Request and line data carry no reset; outputs are gated by state instead.
  always_ff @(posedge clk_i) begin
    if (miss_take) begin
      tag_q    <= miss_tag_i;
      idx_q    <= miss_idx_i;
      victim_q <= victim_sel;
    end
    if (beat_take) line_q[beat_cnt_q*BEAT_WIDHT +: BEAT_WIDHT] <= ifill_resp_data_i;
  end

  assign busy_o            = (state_q != IDLE);
  assign ifill_req_valid_o = (state_q == REQ);
  assign ifill_req_addr_o  = (state_q == REQ) ? {tag_q, idx_q} : '0;
  assign wr_en_o           = (state_q == WRITE) || (state_q == FLUSH);
  assign wr_valid_o        = (state_q == WRITE);
  assign refill_done_o     = (state_q == WRITE);
  assign wr_way_o          = (state_q == WRITE) ? victim_q :
                             (state_q == FLUSH) ? '1 : '0;
  assign wr_idx_o          = (state_q == WRITE) ? idx_q :
                             (state_q == FLUSH) ? set_cnt_q : '0;
  assign wr_tag_o          = (state_q == WRITE) ? tag_q : '0;
  assign wr_data_o         = (state_q == WRITE) ? line_q : '0;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed bench for the icache refill FSM: refills, victim choice, kill, flush, reset.
module tb_sargantana_icache_refill;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         miss_i;
  logic [19:0]  miss_tag_i;
  logic [5:0]   miss_idx_i;
  logic [3:0]   way_valid_bits_i;
  logic         flush_i;
  logic         kill_i;
  logic         ifill_req_valid_o;
  logic [25:0]  ifill_req_addr_o;
  logic         ifill_req_ready_i;
  logic         ifill_resp_valid_i;
  logic [127:0] ifill_resp_data_i;
  logic         wr_en_o;
  logic [3:0]   wr_way_o;
  logic [5:0]   wr_idx_o;
  logic [19:0]  wr_tag_o;
  logic [511:0] wr_data_o;
  logic         wr_valid_o;
  logic         busy_o;
  logic         refill_done_o;

  int checks   = 0;
  int failures = 0;

  sargantana_icache_refill dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .miss_i            (miss_i),
    .miss_tag_i        (miss_tag_i),
    .miss_idx_i        (miss_idx_i),
    .way_valid_bits_i  (way_valid_bits_i),
    .flush_i           (flush_i),
    .kill_i            (kill_i),
    .ifill_req_valid_o (ifill_req_valid_o),
    .ifill_req_addr_o  (ifill_req_addr_o),
    .ifill_req_ready_i (ifill_req_ready_i),
    .ifill_resp_valid_i(ifill_resp_valid_i),
    .ifill_resp_data_i (ifill_resp_data_i),
    .wr_en_o           (wr_en_o),
    .wr_way_o          (wr_way_o),
    .wr_idx_o          (wr_idx_o),
    .wr_tag_o          (wr_tag_o),
    .wr_data_o         (wr_data_o),
    .wr_valid_o        (wr_valid_o),
    .busy_o            (busy_o),
    .refill_done_o     (refill_done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] beat_val(input logic [19:0] tag, input int b);
    return {32'hB000_0000 + 32'(b), 12'h0, tag, 32'h0101_0101 * 32'(b + 1), 32'hCAFE_0000 | 32'(b)};
  endfunction

  // Expects to be called in the first FLUSH cycle; leaves the DUT back in IDLE.
  task automatic flush_check();
    for (int s = 0; s < 64; s++) begin
      chk("flush_en", wr_en_o, 1);
      chk("flush_way", wr_way_o, 4'b1111);
      chk("flush_valid", wr_valid_o, 0);
      chk("flush_idx", wr_idx_o, s);
      chk("flush_noreq", ifill_req_valid_o, 0);
      tick();
    end
    chk("flush_end_busy", busy_o, 0);
    chk("flush_end_en", wr_en_o, 0);
  endtask

  task automatic refill(input logic [19:0] tag, input logic [5:0] idx, input logic [3:0] vbits,
                        input int ready_lat, input int kill_at, input bit pend_flush,
                        input logic [3:0] exp_way);
    logic [511:0] line;
    miss_i = 1; miss_tag_i = tag; miss_idx_i = idx; way_valid_bits_i = vbits;
    tick();
    miss_i = 0; miss_tag_i = '0; miss_idx_i = '0;
    chk("req_valid", ifill_req_valid_o, 1);
    chk("req_addr", ifill_req_addr_o, {tag, idx});
    for (int i = 0; i < ready_lat; i++) begin
      ifill_resp_valid_i = 1; ifill_resp_data_i = 128'hDEAD_BEEF;
      tick();
      chk("req_hold_valid", ifill_req_valid_o, 1);
      chk("req_hold_addr", ifill_req_addr_o, {tag, idx});
    end
    ifill_resp_valid_i = 0;
    ifill_req_ready_i = 1;
    flush_i = pend_flush;
    tick();
    ifill_req_ready_i = 0; flush_i = 0;
    chk("req_dropped", ifill_req_valid_o, 0);
    chk("wait_busy", busy_o, 1);
    for (int b = 0; b < 4; b++) begin
      line[b*128 +: 128] = beat_val(tag, b);
      ifill_resp_valid_i = 1; ifill_resp_data_i = beat_val(tag, b);
      kill_i = (b == kill_at);
      tick();
      kill_i = 0;
      if (b < 3) begin
        chk("wait_no_wr", wr_en_o, 0);
        chk("wait_busy2", busy_o, 1);
      end
    end
    ifill_resp_valid_i = 0; ifill_resp_data_i = '0;
    if (kill_at < 0) begin
      chk("wr_en", wr_en_o, 1);
      chk("wr_way", wr_way_o, exp_way);
      chk("wr_data", wr_data_o, line);
      chk("wr_tag", wr_tag_o, tag);
      chk("wr_idx", wr_idx_o, idx);
      chk("wr_valid", wr_valid_o, 1);
      chk("done", refill_done_o, 1);
      tick();
      chk("post_wr_busy", busy_o, 0);
      chk("post_wr_en", wr_en_o, 0);
      chk("post_done", refill_done_o, 0);
      if (pend_flush) begin
        tick();
        flush_check();
      end
    end else begin
      chk("kill_wr_en", wr_en_o, 0);
      chk("kill_done", refill_done_o, 0);
      chk("kill_busy", busy_o, 0);
    end
  endtask

  initial begin
    rst_i = 1; miss_i = 0; miss_tag_i = '0; miss_idx_i = '0; way_valid_bits_i = '0;
    flush_i = 0; kill_i = 0; ifill_req_ready_i = 0; ifill_resp_valid_i = 0; ifill_resp_data_i = '0;
    tick();
    tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_req", ifill_req_valid_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_done", refill_done_o, 0);
    chk("rst_way", wr_way_o, 0);
    rst_i = 0;
    tick();

    // Invalid way 1 is the victim; ready held off 5 cycles with stray responses.
    refill(20'h12345, 6'd5, 4'b0101, 5, -1, 0, 4'b0010);
    // All valid: round-robin from 0.
    refill(20'h00AA1, 6'd1, 4'b1111, 0, -1, 0, 4'b0001);
    refill(20'h00AA2, 6'd2, 4'b1111, 1, -1, 0, 4'b0010);
    refill(20'h00AA3, 6'd3, 4'b1111, 0, -1, 0, 4'b0100);
    // Killed refill must not advance the pointer (still at 3).
    refill(20'h0BEEF, 6'd9, 4'b1111, 0, 1, 0, 4'b1000);
    refill(20'h0C0DE, 6'd10, 4'b1111, 0, -1, 0, 4'b1000);
    // Flush raised mid-refill runs after the write completes.
    refill(20'hFFFFF, 6'd63, 4'b1110, 2, -1, 1, 4'b0001);

    // Flush and miss together: flush wins, miss is dropped.
    miss_i = 1; miss_tag_i = 20'h55555; miss_idx_i = 6'd7; way_valid_bits_i = 4'b0000; flush_i = 1;
    tick();
    miss_i = 0; flush_i = 0;
    flush_check();
    tick();
    chk("flush_miss_noreq", ifill_req_valid_o, 0);
    chk("flush_miss_idle", busy_o, 0);

    // Advance pointer to 1, then reset mid-WAIT and confirm everything restarts clean.
    refill(20'h01111, 6'd11, 4'b1111, 0, -1, 0, 4'b0001);
    miss_i = 1; miss_tag_i = 20'h02222; miss_idx_i = 6'd12; way_valid_bits_i = 4'b1111;
    tick();
    miss_i = 0; ifill_req_ready_i = 1;
    tick();
    ifill_req_ready_i = 0; ifill_resp_valid_i = 1; ifill_resp_data_i = 128'h1234;
    tick();
    ifill_resp_valid_i = 0;
    chk("pre_rst_busy", busy_o, 1);
    rst_i = 1;
    #1;
    chk("async_rst_busy", busy_o, 0);
    tick();
    chk("rst_wait_busy", busy_o, 0);
    chk("rst_wait_req", ifill_req_valid_o, 0);
    chk("rst_wait_wr_en", wr_en_o, 0);
    chk("rst_wait_data", wr_data_o, 0);
    rst_i = 0;
    tick();
    refill(20'h03333, 6'd13, 4'b1111, 0, -1, 0, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill.md
SARGANTANA_ICACHE_REFILL -- requirements
Module: sargantana_icache_refill

Interface
REQ-001 Parameter ICACHE_N_WAY SHALL be provided, default 4, number of ways.
REQ-002 Parameter TAG_WIDHT SHALL be provided, default 20, tag width.
REQ-003 Parameter IDX_WIDHT SHALL be provided, default 6, set-index width (N_SETS = 2**IDX_WIDHT).
REQ-004 Parameter WAY_WIDHT SHALL be provided, default 512, line width.
REQ-005 Parameter BEAT_WIDHT SHALL be provided, default 128, L2 response beat width (N_BEATS = WAY_WIDHT/BEAT_WIDHT).
REQ-006 One clock; reset is asynchronous and active-high: clk_i in 1, rst_i in 1.
REQ-007 miss_i in 1: the tag-check stage reports a lookup this cycle with no way hit.
REQ-008 miss_tag_i in TAG_WIDHT, miss_idx_i in IDX_WIDHT: physical tag and set of the missing line.
REQ-009 way_valid_bits_i in ICACHE_N_WAY: valid bits of set miss_idx_i.
REQ-010 flush_i in 1: invalidate the whole cache (fence.i); kill_i in 1: discard the in-flight refill.
REQ-011 ifill_req_valid_o out 1, ifill_req_addr_o out TAG_WIDHT+IDX_WIDHT ({tag,idx}), ifill_req_ready_i in 1.
REQ-012 ifill_resp_valid_i in 1, ifill_resp_data_i in BEAT_WIDHT: in-order beats, beat 0 first.
REQ-013 wr_en_o out 1, wr_way_o out ICACHE_N_WAY (one-hot, or all-ones during flush), wr_idx_o out IDX_WIDHT, wr_tag_o out TAG_WIDHT, wr_data_o out WAY_WIDHT, wr_valid_o out 1.
REQ-014 busy_o out 1 (state != IDLE); refill_done_o out 1 (single-cycle pulse).

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, WRITE, FLUSH.
REQ-016 IDLE: flush_i (or pending flush) -> FLUSH with set counter 0; else miss_i -> latch tag/idx, latch victim, -> REQ; flush has priority and a simultaneous miss is dropped.
REQ-017 Victim: lowest-index way with way_valid_bits_i=0; if all valid, the round-robin pointer way.
REQ-018 Round-robin pointer SHALL advance (mod ICACHE_N_WAY) only on a WRITE whose victim came from the pointer.
REQ-019 REQ: ifill_req_valid_o=1 with stable address until ifill_req_ready_i=1; then -> WAIT, beat counter 0; valid SHALL NOT drop before acceptance.
REQ-020 WAIT: each ifill_resp_valid_i beat SHALL be stored at bits [cnt*BEAT_WIDHT +: BEAT_WIDHT], counter increments; on beat N_BEATS-1 -> WRITE, or IDLE if kill flag set.
REQ-021 ifill_resp_valid_i outside WAIT SHALL be ignored.
REQ-022 kill_i in REQ or WAIT SHALL set a kill flag; request still completes and all beats are drained; no write, no refill_done_o; kill_i in IDLE/WRITE/FLUSH ignored.
REQ-023 WRITE (1 cycle): wr_en_o=1, wr_valid_o=1, wr_way_o=victim, wr_tag_o/wr_idx_o=latched, wr_data_o=assembled line, refill_done_o=1; -> IDLE.
REQ-024 FLUSH: per cycle wr_en_o=1, wr_way_o=all-ones, wr_valid_o=0, wr_idx_o=counter; after set N_SETS-1 -> IDLE; miss_i ignored.
REQ-025 flush_i outside IDLE SHALL set a pending flag, serviced on next IDLE entry.
REQ-026 Latency: miss_i to ifill_req_valid_o = 1 cycle; last beat to wr_en_o = 1 cycle; busy_o low the cycle after WRITE.
REQ-027 wr_en_o SHALL be 0 in IDLE, REQ, WAIT.

Reset
REQ-028 rst_i SHALL force IDLE, all outputs 0, pointer 0, beat counter 0, kill and pending-flush flags 0, at any time incl. mid-refill; line buffer not reset.

Structure
REQ-029 State enum and default parameter constants SHALL live in sargantana_icache_pkg.
REQ-030 Victim selection (invalid-first + RR pointer) SHALL be sub-module sargantana_icache_victim_sel.

Verification
REQ-031 Miss tag 0x12345 idx 5, valid 4'b0101, beats A,B,C,D -> req_addr {0x12345,6'd5}; wr_way 4'b0010, wr_data {D,C,B,A}, wr_en 1 cycle after D.
REQ-032 All valid, three misses from reset -> wr_way 0001, 0010, 0100.
REQ-033 kill_i after beat 1 -> beats 2-3 drained, wr_en_o and refill_done_o stay 0, busy_o low after beat 3.
REQ-034 flush_i in IDLE -> 64 cycles wr_en_o=1, wr_way 1111, wr_valid 0, idx 0..63; flush_i + miss_i together -> no request issued.
REQ-035 ifill_req_ready_i low 5 cycles -> req valid/addr stable; rst_i mid-WAIT -> IDLE, outputs 0 next edge.
